// File: rtl/ufo_pkg.sv
// ---------------------------------------------------------------------------
// ufo_pkg -- shared definitions for the UFO scheduler.
//   state_e   : round FSM encoding, also driven on the scheduler's state port
//   wall_e    : spawn wall codes (which edge of the 8x8 field a UFO enters)
//   draw_t    : one spawn draw (wall + position along that wall)
//   UFO_STEPS : default cells travelled per UFO life
//   LFSR_*    : seed and Galois tap mask of the spawn LFSR
// ---------------------------------------------------------------------------
package ufo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SPAWN = 2'd1,
        ST_RUN   = 2'd2,
        ST_END   = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        WALL_TOP    = 2'd0,  // enters at (pos,0), moves y+1
        WALL_RIGHT  = 2'd1,  // enters at (7,pos), moves x-1
        WALL_BOTTOM = 2'd2,  // enters at (pos,7), moves y-1
        WALL_LEFT   = 2'd3   // enters at (0,pos), moves x+1
    } wall_e;

    typedef struct packed {
        logic [1:0] wall;
        logic [2:0] pos;
    } draw_t;

    localparam int          UFO_STEPS = 8;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // x^16+x^14+x^13+x^11+1 in right-shifting Galois form
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/ufo_slot.sv
// ---------------------------------------------------------------------------
// ufo_slot -- registers and move/respawn logic for a single UFO.
//   clk, reset      : clock, async active-low reset
//   clear           : kill the slot (round end)
//   spawn           : bring the slot to life from draw, steps=0
//   tick            : advance strobe; an alive slot moves one cell, or
//                     respawns from draw once it has used up its steps
//   draw            : wall/pos to use for a spawn or respawn
//   vis, x, y       : current visibility and position
//   nxt_vis/x/y     : next-state values, used to build the registered map
// ---------------------------------------------------------------------------
module ufo_slot
    import ufo_pkg::*;
#(
    parameter int STEPS = UFO_STEPS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       spawn,
    input  logic       tick,
    input  draw_t      draw,
    output logic       vis,
    output logic [2:0] x,
    output logic [2:0] y,
    output logic       nxt_vis,
    output logic [2:0] nxt_x,
    output logic [2:0] nxt_y
);

    localparam logic [3:0] STEPS_L = 4'(STEPS);

    logic       alive_q, alive_d;
    logic [3:0] steps_q, steps_d;
    logic [2:0] x_q, x_d, y_q, y_d;
    logic [1:0] wall_q, wall_d;
    logic       expired;

    // A slot that has walked all its steps sits invisible until the next tick.
    assign expired = alive_q && (steps_q == STEPS_L);

    always_comb begin
        alive_d = alive_q;
        steps_d = steps_q;
        x_d     = x_q;
        y_d     = y_q;
        wall_d  = wall_q;
        if (clear) begin
            alive_d = 1'b0;
            steps_d = 4'd0;
            x_d     = 3'd0;
            y_d     = 3'd0;
            wall_d  = 2'd0;
        end else if (spawn || (tick && expired)) begin
            alive_d = 1'b1;
            steps_d = 4'd0;
            wall_d  = draw.wall;
            case (wall_e'(draw.wall))
                WALL_TOP:    begin x_d = draw.pos; y_d = 3'd0;     end
                WALL_RIGHT:  begin x_d = 3'd7;     y_d = draw.pos; end
                WALL_BOTTOM: begin x_d = draw.pos; y_d = 3'd7;     end
                WALL_LEFT:   begin x_d = 3'd0;     y_d = draw.pos; end
            endcase
        end else if (tick && alive_q) begin
            steps_d = steps_q + 4'd1;
            // 3-bit arithmetic gives the mod-8 wrap for free
            case (wall_e'(wall_q))
                WALL_TOP:    y_d = y_q + 3'd1;
                WALL_RIGHT:  x_d = x_q - 3'd1;
                WALL_BOTTOM: y_d = y_q - 3'd1;
                WALL_LEFT:   x_d = x_q + 3'd1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alive_q <= 1'b0;
            steps_q <= 4'd0;
            x_q     <= 3'd0;
            y_q     <= 3'd0;
            wall_q  <= 2'd0;
        end else begin
            alive_q <= alive_d;
            steps_q <= steps_d;
            x_q     <= x_d;
            y_q     <= y_d;
            wall_q  <= wall_d;
        end
    end

    assign vis     = alive_q && (steps_q != STEPS_L);
    assign x       = x_q;
    assign y       = y_q;
    assign nxt_vis = alive_d && (steps_d != STEPS_L);
    assign nxt_x   = x_d;
    assign nxt_y   = y_d;

endmodule

// File: rtl/ufo_scheduler.sv
// ---------------------------------------------------------------------------
// ufo_scheduler -- spawns, moves and collides UFOs on an 8x8 field.
//   clk, reset          : clock, async active-low reset
//   start               : begin a round (only honoured in IDLE)
//   step_tick           : UFO advance strobe
//   level               : round difficulty, level+1 UFOs (latched at start)
//   player_x/player_y   : player cell
//   time_up             : round timer expired
//   cfg_fixed/wall/pos  : force spawn draws instead of using the LFSR
//   ufo_map             : bit x+8*y set where a visible UFO sits
//   hit, timeout        : one-cycle round-end pulses
//   state               : IDLE=0, SPAWN=1, RUN=2, END=3
// ---------------------------------------------------------------------------
module ufo_scheduler
    import ufo_pkg::*;
#(
    parameter int NSLOT = 4,
    parameter int STEPS = UFO_STEPS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        step_tick,
    input  logic [1:0]  level,
    input  logic [2:0]  player_x,
    input  logic [2:0]  player_y,
    input  logic        time_up,
    input  logic        cfg_fixed,
    input  logic [1:0]  cfg_wall,
    input  logic [2:0]  cfg_pos,
    output logic [63:0] ufo_map,
    output logic        hit,
    output logic        timeout,
    output logic [1:0]  state
);

    state_e      state_q, state_d;
    logic [63:0] map_q, map_d;
    logic        hit_q, hit_d;
    logic        to_q, to_d;
    logic [2:0]  n_act_q, n_act_d;
    logic [2:0]  spawn_idx_q, spawn_idx_d;
    logic [15:0] lfsr_q, lfsr_d;

    logic        in_round, collide, end_round, tick_go;
    draw_t       draw;

    logic [NSLOT-1:0]       slot_spawn, slot_vis, nxt_vis;
    logic [NSLOT-1:0][2:0]  slot_x, slot_y, nxt_x, nxt_y;

    assign in_round = (state_q == ST_SPAWN) || (state_q == ST_RUN);
    assign lfsr_d   = lfsr_next(lfsr_q);
    assign draw     = cfg_fixed ? draw_t'{wall: cfg_wall,    pos: cfg_pos}
                                : draw_t'{wall: lfsr_q[1:0], pos: lfsr_q[4:2]};

    always_comb begin
        collide = 1'b0;
        for (int i = 0; i < NSLOT; i++) begin
            if (slot_vis[i] && (slot_x[i] == player_x) && (slot_y[i] == player_y))
                collide = 1'b1;
        end
        collide = collide && in_round;
    end

    // Round end beats any tick in the same cycle: the slots are cleared.
    assign end_round = in_round && (collide || time_up);
    assign tick_go   = in_round && step_tick && !end_round;

    for (genvar i = 0; i < NSLOT; i++) begin : g_slot
        assign slot_spawn[i] = tick_go && (state_q == ST_SPAWN) && (spawn_idx_q == 3'(i));

        ufo_slot #(.STEPS(STEPS)) u_slot (
            .clk     (clk),
            .reset   (reset),
            .clear   (end_round),
            .spawn   (slot_spawn[i]),
            .tick    (tick_go),
            .draw    (draw),
            .vis     (slot_vis[i]),
            .x       (slot_x[i]),
            .y       (slot_y[i]),
            .nxt_vis (nxt_vis[i]),
            .nxt_x   (nxt_x[i]),
            .nxt_y   (nxt_y[i])
        );
    end

    // Map is built from next-state positions so it lines up with the slots.
    always_comb begin
        map_d = '0;
        if (in_round && !end_round) begin
            for (int i = 0; i < NSLOT; i++) begin
                if (nxt_vis[i]) map_d[{nxt_y[i], nxt_x[i]}] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        n_act_d     = n_act_q;
        spawn_idx_d = spawn_idx_q;
        hit_d       = 1'b0;
        to_d        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_SPAWN;
                    spawn_idx_d = 3'd0;
                    if (int'(level) + 1 > NSLOT) n_act_d = 3'(NSLOT);
                    else                         n_act_d = {1'b0, level} + 3'd1;
                end
            end
            ST_SPAWN: begin
                if (end_round) begin
                    state_d = ST_END;
                    hit_d   = collide;
                    to_d    = !collide;
                end else if (tick_go) begin
                    spawn_idx_d = spawn_idx_q + 3'd1;
                    if (spawn_idx_q == n_act_q - 3'd1) state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (end_round) begin
                    state_d = ST_END;
                    hit_d   = collide;
                    to_d    = !collide;
                end
            end
            ST_END: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            map_q       <= '0;
            hit_q       <= 1'b0;
            to_q        <= 1'b0;
            n_act_q     <= 3'd0;
            spawn_idx_q <= 3'd0;
            lfsr_q      <= LFSR_SEED;
        end else begin
            state_q     <= state_d;
            map_q       <= map_d;
            hit_q       <= hit_d;
            to_q        <= to_d;
            n_act_q     <= n_act_d;
            spawn_idx_q <= spawn_idx_d;
            lfsr_q      <= lfsr_d;
        end
    end

    assign ufo_map = map_q;
    assign hit     = hit_q;
    assign timeout = to_q;
    assign state   = state_q;

endmodule

// File: tb/tb_ufo_scheduler.sv
module tb_ufo_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0, step_tick = 1'b0, time_up = 1'b0;
    logic [1:0]  level = 2'd0;
    logic [2:0]  player_x = 3'd0, player_y = 3'd0;
    logic        cfg_fixed = 1'b1;
    logic [1:0]  cfg_wall = 2'd0;
    logic [2:0]  cfg_pos = 3'd0;
    logic [63:0] ufo_map;
    logic        hit, timeout;
    logic [1:0]  state;

    localparam logic [1:0] S_IDLE = 2'd0, S_SPAWN = 2'd1, S_RUN = 2'd2, S_END = 2'd3;

    ufo_scheduler #(.NSLOT(4), .STEPS(8)) dut (
        .clk(clk), .reset(rst_n), .start(start), .step_tick(step_tick),
        .level(level), .player_x(player_x), .player_y(player_y),
        .time_up(time_up), .cfg_fixed(cfg_fixed), .cfg_wall(cfg_wall),
        .cfg_pos(cfg_pos), .ufo_map(ufo_map), .hit(hit), .timeout(timeout),
        .state(state)
    );

    always #5 clk = ~clk;

    // Reference LFSR, stepped on the same edges as the design's.
    logic [15:0] m_lfsr;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 16'hACE1;
        else        m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    typedef struct packed {
        logic [1:0]  st;
        logic        hit;
        logic        to;
        logic [63:0] map;
    } obs_t;

    typedef struct {
        logic       tk;
        logic       sr;
        logic       tu;
        logic [1:0] lv;
        obs_t       e;
        string      nm;
    } step_t;

    obs_t sb[$];
    int   checks = 0;
    int   failures = 0;

    function automatic obs_t cur();
        obs_t o;
        o.st = state; o.hit = hit; o.to = timeout; o.map = ufo_map;
        return o;
    endfunction

    function automatic obs_t ex(input logic [1:0] st, input logic h, input logic t, input logic [63:0] m);
        obs_t o;
        o.st = st; o.hit = h; o.to = t; o.map = m;
        return o;
    endfunction

    function automatic logic [63:0] bt(input int x, input int y);
        logic [63:0] v;
        v = '0;
        v[x + 8 * y] = 1'b1;
        return v;
    endfunction

    function automatic step_t mk(input logic tk, input logic sr, input logic tu,
                                 input logic [1:0] lv, input obs_t e, input string nm);
        step_t s;
        s.tk = tk; s.sr = sr; s.tu = tu; s.lv = lv; s.e = e; s.nm = nm;
        return s;
    endfunction

    // Drives one cycle of inputs at the falling edge; returns #1 after the rising edge.
    task automatic drive_cycle(input logic tk, input logic sr, input logic tu, input logic [1:0] lv);
        @(negedge clk);
        step_tick = tk; start = sr; time_up = tu; level = lv;
        @(posedge clk);
        #1;
        step_tick = 1'b0; start = 1'b0; time_up = 1'b0;
    endtask

    task automatic test_reset();
        obs_t e, o;
        #1 rst_n = 1'b0;
        start = 1'b1;
        #2;
        sb.push_back(ex(S_IDLE, 1'b0, 1'b0, 64'h0));
        e = sb.pop_front(); o = cur(); checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL reset_hold: got st=%0d hit=%b to=%b map=%h, want st=%0d hit=%b to=%b map=%h",
                     o.st, o.hit, o.to, o.map, e.st, e.hit, e.to, e.map);
        end
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back(ex(S_IDLE, 1'b0, 1'b0, 64'h0));
        e = sb.pop_front(); o = cur(); checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL reset_release: got st=%0d hit=%b to=%b map=%h, want st=%0d hit=%b to=%b map=%h",
                     o.st, o.hit, o.to, o.map, e.st, e.hit, e.to, e.map);
        end
        // tick and time_up are meaningless in IDLE
        sb.push_back(ex(S_IDLE, 1'b0, 1'b0, 64'h0));
        drive_cycle(1'b1, 1'b0, 1'b1, 2'd0);
        e = sb.pop_front(); o = cur(); checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL idle_ignore: got st=%0d hit=%b to=%b map=%h, want st=%0d hit=%b to=%b map=%h",
                     o.st, o.hit, o.to, o.map, e.st, e.hit, e.to, e.map);
        end
    endtask

    task automatic test_spawn_motion();
        step_t tbl[$];
        obs_t  e, o;
        cfg_fixed = 1'b1; cfg_wall = 2'd0; cfg_pos = 3'd3; player_x = 3'd0; player_y = 3'd0;
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 2'd0, ex(S_SPAWN, 1'b0, 1'b0, 64'h0), "start"));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 2'd0, ex(S_RUN, 1'b0, 1'b0, bt(3, 0)), "spawn_tick1"));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 2'd0, ex(S_RUN, 1'b0, 1'b0, bt(3, 0)), "start_in_run"));
        for (int k = 2; k <= 8; k++)
            tbl.push_back(mk(1'b1, 1'b0, 1'b0, 2'd0, ex(S_RUN, 1'b0, 1'b0, bt(3, k - 1)), "motion"));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 2'd0, ex(S_RUN, 1'b0, 1'b0, 64'h0), "invisible_t9"));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 2'd0, ex(S_RUN, 1'b0, 1'b0, bt(3, 0)), "respawn_t10"));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 2'd0, ex(S_END, 1'b0, 1'b1, 64'h0), "timeout"));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 2'd0, ex(S_IDLE, 1'b0, 1'b0, 64'h0), "end_to_idle"));
        foreach (tbl[i]) begin
            sb.push_back(tbl[i].e);
            drive_cycle(tbl[i].tk, tbl[i].sr, tbl[i].tu, tbl[i].lv);
            e = sb.pop_front(); o = cur(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL %s[%0d]: got st=%0d hit=%b to=%b map=%h, want st=%0d hit=%b to=%b map=%h",
                         tbl[i].nm, i, o.st, o.hit, o.to, o.map, e.st, e.hit, e.to, e.map);
            end
        end
    endtask

    task automatic test_collision(input logic tie);
        step_t tbl[$];
        obs_t  e, o;
        cfg_fixed = 1'b1; cfg_wall = 2'd0; cfg_pos = 3'd3; player_x = 3'd3; player_y = 3'd2;
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 2'd0, ex(S_SPAWN, 1'b0, 1'b0, 64'h0), "col_start"));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 2'd0, ex(S_RUN, 1'b0, 1'b0, bt(3, 0)), "col_t1"));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 2'd0, ex(S_RUN, 1'b0, 1'b0, bt(3, 1)), "col_t2"));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 2'd0, ex(S_RUN, 1'b0, 1'b0, bt(3, 2)), "col_t3"));
        tbl.push_back(mk(1'b1, 1'b0, tie, 2'd0, ex(S_END, 1'b1, 1'b0, 64'h0), tie ? "tie_hit" : "col_hit"));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 2'd0, ex(S_IDLE, 1'b0, 1'b0, 64'h0), "col_idle"));
        foreach (tbl[i]) begin
            sb.push_back(tbl[i].e);
            drive_cycle(tbl[i].tk, tbl[i].sr, tbl[i].tu, tbl[i].lv);
            e = sb.pop_front(); o = cur(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL %s: got st=%0d hit=%b to=%b map=%h, want st=%0d hit=%b to=%b map=%h",
                         tbl[i].nm, o.st, o.hit, o.to, o.map, e.st, e.hit, e.to, e.map);
            end
        end
    endtask

    task automatic test_walls();
        int    pos[3] = '{5, 2, 4};
        int    sx[3]  = '{7, 2, 0};
        int    sy[3]  = '{5, 7, 4};
        int    mx[3]  = '{6, 2, 1};
        int    my[3]  = '{5, 6, 4};
        step_t tbl[$];
        obs_t  e, o;
        player_x = 3'd0; player_y = 3'd0; cfg_fixed = 1'b1;
        for (int w = 1; w <= 3; w++) begin
            cfg_wall = 2'(w); cfg_pos = 3'(pos[w - 1]);
            tbl.delete();
            tbl.push_back(mk(1'b0, 1'b1, 1'b0, 2'd0, ex(S_SPAWN, 1'b0, 1'b0, 64'h0), "wall_start"));
            tbl.push_back(mk(1'b1, 1'b0, 1'b0, 2'd0, ex(S_RUN, 1'b0, 1'b0, bt(sx[w - 1], sy[w - 1])), "wall_entry"));
            tbl.push_back(mk(1'b1, 1'b0, 1'b0, 2'd0, ex(S_RUN, 1'b0, 1'b0, bt(mx[w - 1], my[w - 1])), "wall_move"));
            tbl.push_back(mk(1'b0, 1'b0, 1'b1, 2'd0, ex(S_END, 1'b0, 1'b1, 64'h0), "wall_timeout"));
            tbl.push_back(mk(1'b0, 1'b0, 1'b0, 2'd0, ex(S_IDLE, 1'b0, 1'b0, 64'h0), "wall_idle"));
            foreach (tbl[i]) begin
                sb.push_back(tbl[i].e);
                drive_cycle(tbl[i].tk, tbl[i].sr, tbl[i].tu, tbl[i].lv);
                e = sb.pop_front(); o = cur(); checks++;
                if (o !== e) begin
                    failures++;
                    $display("FAIL %s w%0d: got st=%0d hit=%b to=%b map=%h, want st=%0d hit=%b to=%b map=%h",
                             tbl[i].nm, w, o.st, o.hit, o.to, o.map, e.st, e.hit, e.to, e.map);
                end
            end
        end
    endtask

    task automatic test_multi();
        step_t tbl[$];
        obs_t  e, o;
        cfg_fixed = 1'b1; cfg_wall = 2'd0; cfg_pos = 3'd3; player_x = 3'd0; player_y = 3'd0;
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 2'd3, ex(S_SPAWN, 1'b0, 1'b0, 64'h0), "multi_start"));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 2'd3, ex(S_SPAWN, 1'b0, 1'b0, bt(3, 0)), "multi_t1"));
        // level drop and a stray start mid-round must not matter
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 2'd0, ex(S_SPAWN, 1'b0, 1'b0, bt(3, 0) | bt(3, 1)), "multi_t2"));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 2'd0,
                         ex(S_SPAWN, 1'b0, 1'b0, bt(3, 0) | bt(3, 1) | bt(3, 2)), "multi_t3"));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 2'd0,
                         ex(S_RUN, 1'b0, 1'b0, bt(3, 0) | bt(3, 1) | bt(3, 2) | bt(3, 3)), "multi_t4"));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 2'd0,
                         ex(S_RUN, 1'b0, 1'b0, bt(3, 1) | bt(3, 2) | bt(3, 3) | bt(3, 4)), "multi_t5"));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 2'd0, ex(S_END, 1'b0, 1'b1, 64'h0), "multi_timeout"));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 2'd0, ex(S_IDLE, 1'b0, 1'b0, 64'h0), "multi_idle"));
        foreach (tbl[i]) begin
            sb.push_back(tbl[i].e);
            drive_cycle(tbl[i].tk, tbl[i].sr, tbl[i].tu, tbl[i].lv);
            e = sb.pop_front(); o = cur(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL %s: got st=%0d hit=%b to=%b map=%h, want st=%0d hit=%b to=%b map=%h",
                         tbl[i].nm, o.st, o.hit, o.to, o.map, e.st, e.hit, e.to, e.map);
            end
        end
    endtask

    task automatic test_lfsr();
        obs_t        e, o;
        logic [15:0] lf;
        int          w, p, cx, cy, nx, ny;
        cfg_fixed = 1'b0;
        for (int r = 0; r < 3; r++) begin
            sb.push_back(ex(S_SPAWN, 1'b0, 1'b0, 64'h0));
            drive_cycle(1'b0, 1'b1, 1'b0, 2'd0);
            e = sb.pop_front(); o = cur(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL lfsr_start: got st=%0d map=%h, want st=%0d map=%h", o.st, o.map, e.st, e.map);
            end
            repeat (r * 3) @(posedge clk);
            @(negedge clk);
            lf = m_lfsr;
            w = int'(lf[1:0]); p = int'(lf[4:2]);
            case (w)
                0:       begin cx = p; cy = 0; end
                1:       begin cx = 7; cy = p; end
                2:       begin cx = p; cy = 7; end
                default: begin cx = 0; cy = p; end
            endcase
            nx = cx; ny = cy;
            case (w)
                0:       ny = (cy + 1) % 8;
                1:       nx = (cx + 7) % 8;
                2:       ny = (cy + 7) % 8;
                default: nx = (cx + 1) % 8;
            endcase
            player_x = 3'(cx ^ 4); player_y = 3'(cy);
            step_tick = 1'b1;
            sb.push_back(ex(S_RUN, 1'b0, 1'b0, bt(cx, cy)));
            @(posedge clk);
            #1 step_tick = 1'b0;
            e = sb.pop_front(); o = cur(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL lfsr_spawn lf=%h: got st=%0d map=%h, want st=%0d map=%h", lf, o.st, o.map, e.st, e.map);
            end
            sb.push_back(ex(S_RUN, 1'b0, 1'b0, bt(nx, ny)));
            drive_cycle(1'b1, 1'b0, 1'b0, 2'd0);
            e = sb.pop_front(); o = cur(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL lfsr_move lf=%h: got st=%0d map=%h, want st=%0d map=%h", lf, o.st, o.map, e.st, e.map);
            end
            sb.push_back(ex(S_END, 1'b0, 1'b1, 64'h0));
            drive_cycle(1'b0, 1'b0, 1'b1, 2'd0);
            e = sb.pop_front(); o = cur(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL lfsr_end: got st=%0d to=%b, want st=%0d to=%b", o.st, o.to, e.st, e.to);
            end
            drive_cycle(1'b0, 1'b0, 1'b0, 2'd0);
        end
        cfg_fixed = 1'b1;
    endtask

    task automatic test_reset_mid();
        step_t tbl[$];
        obs_t  e, o;
        cfg_fixed = 1'b1; cfg_wall = 2'd0; cfg_pos = 3'd3; player_x = 3'd3; player_y = 3'd1;
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 2'd0, ex(S_SPAWN, 1'b0, 1'b0, 64'h0), "rm_start"));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 2'd0, ex(S_RUN, 1'b0, 1'b0, bt(3, 0)), "rm_t1"));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 2'd0, ex(S_RUN, 1'b0, 1'b0, bt(3, 1)), "rm_t2"));
        foreach (tbl[i]) begin
            sb.push_back(tbl[i].e);
            drive_cycle(tbl[i].tk, tbl[i].sr, tbl[i].tu, tbl[i].lv);
            e = sb.pop_front(); o = cur(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL %s: got st=%0d hit=%b to=%b map=%h, want st=%0d hit=%b to=%b map=%h",
                         tbl[i].nm, o.st, o.hit, o.to, o.map, e.st, e.hit, e.to, e.map);
            end
        end
        // A collision is pending right now; reset must swallow it.
        #1 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            sb.push_back(ex(S_IDLE, 1'b0, 1'b0, 64'h0));
            e = sb.pop_front(); o = cur(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL rm_abort[%0d]: got st=%0d hit=%b to=%b map=%h, want all zero", k, o.st, o.hit, o.to, o.map);
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        rst_n = 1'b1;
        player_x = 3'd0; player_y = 3'd0;
        tbl.delete();
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 2'd0, ex(S_IDLE, 1'b0, 1'b0, 64'h0), "rm_no_hit"));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 2'd0, ex(S_SPAWN, 1'b0, 1'b0, 64'h0), "rm_restart"));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 2'd0, ex(S_RUN, 1'b0, 1'b0, bt(3, 0)), "rm_respawn"));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 2'd0, ex(S_END, 1'b0, 1'b1, 64'h0), "rm_timeout"));
        foreach (tbl[i]) begin
            sb.push_back(tbl[i].e);
            drive_cycle(tbl[i].tk, tbl[i].sr, tbl[i].tu, tbl[i].lv);
            e = sb.pop_front(); o = cur(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL %s: got st=%0d hit=%b to=%b map=%h, want st=%0d hit=%b to=%b map=%h",
                         tbl[i].nm, o.st, o.hit, o.to, o.map, e.st, e.hit, e.to, e.map);
            end
        end
        drive_cycle(1'b0, 1'b0, 1'b0, 2'd0);
    endtask

    initial begin
        test_reset();
        test_spawn_motion();
        test_collision(1'b0);
        test_collision(1'b1);
        test_walls();
        test_multi();
        test_lfsr();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

endmodule

// File: doc/ufo_scheduler.md
UFO_SCHEDULER -- requirements
Module: ufo_scheduler

Interface
REQ-001 SHALL have parameter NSLOT, default 4, meaning maximum UFO slots.
REQ-002 SHALL have parameter STEPS, default 8, meaning cells travelled per UFO life.
REQ-003 SHALL have port clk, input, 1, the single system clock.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, one-cycle pulse that begins a round.
REQ-006 SHALL have port step_tick, input, 1, one-cycle UFO advance strobe.
REQ-007 SHALL have port level, input, 2, where active slots = level+1.
REQ-008 SHALL have port player_x, input, 3, player column.
REQ-009 SHALL have port player_y, input, 3, player row.
REQ-010 SHALL have port time_up, input, 1, round timer expired (level).
REQ-011 SHALL have port cfg_fixed, input, 1; when 1, spawns use cfg_wall/cfg_pos instead of the LFSR.
REQ-012 SHALL have ports cfg_wall, input, 2, and cfg_pos, input, 3, the forced spawn values.
REQ-013 SHALL have port ufo_map, output, 64, where bit x+8*y=1 means a visible UFO at that cell.
REQ-014 SHALL have ports hit, output, 1, and timeout, output, 1, each a one-cycle round-end pulse.
REQ-015 SHALL have port state, output, 2, encoded IDLE=0, SPAWN=1, RUN=2, END=3.

Function
REQ-016 SHALL run a free 16-bit Galois LFSR, poly x^16+x^14+x^13+x^11+1, seed 16'hACE1, advancing every clk.
REQ-017 SHALL take each spawn's wall from lfsr[1:0] and pos from lfsr[4:2], or from cfg_wall/cfg_pos when cfg_fixed=1.
REQ-018 SHALL place and move UFOs by wall: wall0 starts (pos,0), y+1 per step; wall1 starts (7,pos), x-1; wall2 starts (pos,7), y-1; wall3 starts (0,pos), x+1.
REQ-019 SHALL keep per slot: x[2:0], y[2:0], wall[1:0], steps[3:0] (0..STEPS) and alive; position arithmetic is mod 8.
REQ-020 SHALL, in IDLE, hold ufo_map=0 and go to SPAWN on start, latching level into n_act=level+1.
REQ-021 SHALL, in SPAWN, on each step_tick spawn the next slot (index 0 upward) with steps=0 and alive=1, and enter RUN on the tick that spawns slot n_act-1.
REQ-022 SHALL, in SPAWN, also advance already alive slots on each step_tick, in the same way as RUN.
REQ-023 SHALL, in RUN on step_tick, advance each alive slot with steps<STEPS and increment steps; a slot with steps==STEPS respawns instead (new draw, steps=0).
REQ-024 SHALL treat a slot with steps==STEPS as invisible: excluded from ufo_map and from collision.
REQ-025 SHALL register ufo_map from the next-state positions, so the map reflects a tick in the cycle after step_tick.
REQ-026 SHALL detect collision every cycle in SPAWN/RUN: a visible slot equals (player_x, player_y).
REQ-027 SHALL, on collision, pulse hit in the next cycle, enter END, clear all slots and clear ufo_map.
REQ-028 SHALL, on time_up with no collision, pulse timeout instead, with the same END entry.
REQ-029 SHALL, when collision and time_up coincide, pulse hit only.
REQ-030 SHALL stay in END for exactly one cycle, then go to IDLE.
REQ-031 SHALL ignore start outside IDLE.
REQ-032 SHALL ignore level changes in mid-round.
REQ-033 SHALL ignore step_tick in IDLE and END.

Reset
REQ-034 SHALL, while reset=0, force state=IDLE, ufo_map=0, hit=0, timeout=0, all slots dead, steps=0, n_act=0 and lfsr=16'hACE1.
REQ-035 SHALL, on a reset assertion mid-round, abort immediately with no hit or timeout pulse.

Structure
REQ-036 SHALL place the state encoding, wall codes, STEPS and the LFSR seed/taps in shared package ufo_pkg.
REQ-037 SHALL implement one sub-module, ufo_slot (one slot's registers and move/respawn logic), instantiated NSLOT times.

Verification
REQ-038 SHALL cover this spawn case: cfg_fixed=1, wall0, pos3, level=0, start, then 1 tick -> next cycle ufo_map bit 3 set, state=RUN.
REQ-039 SHALL cover this motion case: the same setup plus 7 more ticks -> UFO at (3,7) (bit 59); at tick 9 the slot is invisible (map=0); at tick 10 it respawns at bit 3.
REQ-040 SHALL cover this collision case: player (3,2), wall0, pos3, after the 3rd tick -> hit=1 one cycle later, state END then IDLE, ufo_map=0.
REQ-041 SHALL cover this tie case: time_up=1 in the same cycle as a collision -> hit=1, timeout=0.
REQ-042 SHALL cover this multi-slot case: level=3, cfg_fixed=1 -> slots spawn on ticks 1..4, RUN entered after tick 4, 4 active slots.
REQ-043 SHALL cover this reset case: reset=0 pulse during RUN -> all outputs 0 and state=IDLE with no hit pulse; start afterwards works.
